// File: rtl/pipelined_datapath_pkg.sv
// rtl/pipelined_datapath_pkg.sv - opcode encodings and decode helpers for the two-stage datapath
package pipelined_datapath_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD     = 4'd0;
    localparam alu_op_t OP_SUB     = 4'd1;
    localparam alu_op_t OP_AND     = 4'd2;
    localparam alu_op_t OP_OR      = 4'd3;
    localparam alu_op_t OP_XOR     = 4'd4;
    localparam alu_op_t OP_SLL     = 4'd5;
    localparam alu_op_t OP_SRL     = 4'd6;
    localparam alu_op_t OP_ADDI    = 4'd7;
    localparam alu_op_t OP_NOP_MIN = 4'd8;

    function automatic logic writes_reg(input alu_op_t op);
        return op < OP_NOP_MIN;
    endfunction

    // Opcodes above OP_XOR reinterpret the rs2 field as an immediate.
    function automatic logic reads_rs2(input alu_op_t op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/pipelined_datapath_if.sv
// rtl/pipelined_datapath_if.sv - instruction, init-load and result signals of the datapath
interface pipelined_datapath_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
);
    localparam int RA_W    = $clog2(NREGS);
    localparam int INSTR_W = 4 + 3 * RA_W;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic               init_we;
    logic [RA_W-1:0]    init_addr;
    logic [DATA_W-1:0]  init_data;
    logic               init_ack;
    logic               out_valid;
    logic [DATA_W-1:0]  alu_out;

    modport master (
        output in_valid, instr, init_we, init_addr, init_data,
        input  in_ready, init_ack, out_valid, alu_out
    );

    modport slave (
        input  in_valid, instr, init_we, init_addr, init_data,
        output in_ready, init_ack, out_valid, alu_out
    );
endinterface

// File: rtl/pipelined_datapath_regfile.sv
// rtl/pipelined_datapath_regfile.sv - dp_regfile: two async read ports, one sync write port
module dp_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage decode/execute datapath with RAW handling
// FORWARD_EN selects EX->DE bypass; otherwise a hazard stalls DE for one cycle.
module pipelined_datapath #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipelined_datapath_if.slave   bus
);
    import pipelined_datapath_pkg::*;

    localparam int RA_W = $clog2(NREGS);
    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    alu_op_t           de_op;
    logic [RA_W-1:0]   de_rd, de_rs1, de_rs2;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [DATA_W-1:0] op_a, op_b_reg, op_b;
    logic              hz_a, hz_b, stall, ready, accept;

    logic              ex_valid_q, ex_valid_d;
    alu_op_t           ex_op_q, ex_op_d;
    logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] ex_result;
    logic              ex_writes, init_ack;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign {de_op, de_rd, de_rs1, de_rs2} = bus.instr;

    always_comb begin
        ex_result = '0;
        case (ex_op_q)
            OP_ADD:  ex_result = ex_a_q + ex_b_q;
            OP_SUB:  ex_result = ex_a_q - ex_b_q;
            OP_AND:  ex_result = ex_a_q & ex_b_q;
            OP_OR:   ex_result = ex_a_q | ex_b_q;
            OP_XOR:  ex_result = ex_a_q ^ ex_b_q;
            OP_SLL:  ex_result = (ex_b_q >= SHIFT_LIMIT) ? '0 : ex_a_q << ex_b_q;
            OP_SRL:  ex_result = (ex_b_q >= SHIFT_LIMIT) ? '0 : ex_a_q >> ex_b_q;
            OP_ADDI: ex_result = ex_a_q + ex_b_q;
            default: ex_result = '0;
        endcase
    end

    always_comb begin
        ex_writes = ex_valid_q && writes_reg(ex_op_q);
        hz_a      = ex_writes && writes_reg(de_op) && (ex_rd_q == de_rs1);
        hz_b      = ex_writes && reads_rs2(de_op) && (ex_rd_q == de_rs2);
`ifdef FORWARD_EN
        op_a      = hz_a ? ex_result : rdata_a;
        op_b_reg  = hz_b ? ex_result : rdata_b;
        stall     = 1'b0;
`else
        op_a      = rdata_a;
        op_b_reg  = rdata_b;
        stall     = hz_a | hz_b;
`endif
        op_b      = reads_rs2(de_op) ? op_b_reg : DATA_W'(de_rs2);
        // Init loads own the write port only when EX has nothing to retire.
        ready     = ~bus.init_we & ~stall;
        accept    = bus.in_valid & ready;
        init_ack  = bus.init_we & ~ex_valid_q;
        rf_we     = ex_writes | init_ack;
        rf_waddr  = ex_writes ? ex_rd_q   : bus.init_addr;
        rf_wdata  = ex_writes ? ex_result : bus.init_data;
    end

    always_comb begin
        ex_valid_d  = accept;
        ex_op_d     = ex_op_q;
        ex_rd_d     = ex_rd_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        if (accept) begin
            ex_op_d = de_op;
            ex_rd_d = de_rd;
            ex_a_d  = op_a;
            ex_b_d  = op_b;
        end
        out_valid_d = ex_valid_q;
        alu_out_d   = ex_valid_q ? ex_result : alu_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= OP_ADD;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
        end
    end

    dp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RA_W(RA_W)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (de_rs1),
        .rdata_a (rdata_a),
        .raddr_b (de_rs2),
        .rdata_b (rdata_b)
    );

    assign bus.in_ready  = ready;
    assign bus.init_ack  = init_ack;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - scoreboard bench for pipelined_datapath against an architectural model
module tb_pipelined_datapath;
    parameter int DATA_W = 16;
    parameter int NREGS  = 16;
    localparam int RA_W  = $clog2(NREGS);

    typedef logic [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_datapath_if #(.DATA_W(DATA_W), .NREGS(NREGS)) bus ();

    pipelined_datapath #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_accept = 0;
    int    prev_accept = 0;
    word_t mregs [NREGS];
    word_t expq [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Architectural semantics: instructions take effect in order, one at a time.
    function automatic word_t model(input int op, input int rs1, input int rs2);
        word_t a = mregs[rs1];
        word_t b = mregs[rs2];
        word_t imm = word_t'(rs2);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (rs2 >= DATA_W) ? '0 : a << rs2;
            6: return (rs2 >= DATA_W) ? '0 : a >> rs2;
            7: return a + imm;
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.out_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%0h required=none", bus.alu_out);
            end else begin
                check("alu_out", bus.alu_out, expq.pop_front());
            end
        end
    end

    task automatic issue(input int op, input int rd, input int rs1, input int rs2);
        int    waited = 0;
        word_t res;
        bus.in_valid = 1'b1;
        bus.instr    = {4'(op), RA_W'(rd), RA_W'(rs1), RA_W'(rs2)};
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                res = model(op, rs1, rs2);
                if (op < 8) mregs[rd] = res;
                expq.push_back(res);
                prev_accept = last_accept;
                last_accept = cyc;
                break;
            end
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 64'(waited), 64'd0);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_init(input int addr, input word_t data, output int waited);
        waited = 0;
        bus.init_we   = 1'b1;
        bus.init_addr = RA_W'(addr);
        bus.init_data = data;
        forever begin
            @(negedge clk);
            if (bus.init_ack === 1'b1) begin
                mregs[addr] = data;
                break;
            end
            waited++;
            if (waited > 20) begin
                check("init_ack_timeout", 64'(waited), 64'd0);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        bus.init_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int w;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.init_we   = 1'b0;
        bus.init_addr = '0;
        bus.init_data = '0;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: traffic in flight, then asynchronous reset squashes it
        do_init(1, word_t'(5), w);
        do_init(2, word_t'(7), w);
        issue(0, 3, 1, 2);
        issue(1, 4, 1, 2);
        #1;
        reset_n = 1'b0;
        expq.delete();
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_alu_out", 64'(bus.alu_out), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREGS; i++) issue(0, i, i, i);
        drain();

        // 2: init loads then ADD, with latency check
        do_init(1, word_t'(5), w);
        check("init_r1_wait", 64'(w), 64'd0);
        do_init(2, word_t'(3), w);
        check("init_r2_wait", 64'(w), 64'd0);
        issue(0, 3, 1, 2);
        check("latency_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_two_edges", 64'(bus.out_valid), 64'd1);
        check("add_r3_value", 64'(bus.alu_out), 64'd8);
        drain();

        // 3: back-to-back dependent pair
        issue(1, 4, 1, 2);
        issue(4, 5, 4, 1);
`ifdef FORWARD_EN
        check("raw_accept_gap", 64'(last_accept - prev_accept), 64'd1);
`else
        check("raw_accept_gap", 64'(last_accept - prev_accept), 64'd2);
`endif
        drain();

        // 4: init request arrives while EX holds an instruction
        issue(0, 8, 1, 2);
        bus.init_we   = 1'b1;
        bus.init_addr = RA_W'(9);
        bus.init_data = word_t'(16'h1234);
        #1;
        check("init_blocks_in_ready", 64'(bus.in_ready), 64'd0);
        check("init_waits_for_ex", 64'(bus.init_ack), 64'd0);
        do_init(9, word_t'(16'h1234), w);
        check("init_ack_delay", 64'(w), 64'd1);
        issue(3, 10, 8, 8);
        issue(0, 11, 9, 9);
        drain();

        // 5: wrap-around and shifts at the top of the immediate range
        do_init(1, '1, w);
        issue(7, 6, 1, 1);
        issue(5, 7, 2, NREGS - 1);
        issue(6, 12, 1, NREGS - 1);
        issue(6, 13, 6, 0);
        drain();

        // 6: NOP, then random stream with occasional init loads and gaps
        issue(12, 13, 1, 2);
        issue(0, 14, 13, 13);
        drain();
        for (int n = 0; n < 1000; n++) begin
            int op;
            if ($urandom % 16 == 0) do_init($urandom_range(0, NREGS - 1), word_t'($urandom), w);
            op = ($urandom % 5 == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            issue(op, $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                  $urandom_range(0, NREGS - 1));
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        for (int i = 0; i < NREGS; i++) issue(3, i, i, i);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
